yas_router_n: RTL and testbench

- Parametrised successor of the 3-channel router: one byte-serial input port, NUM_CH output channels, store-and-forward packet FIFOs per channel.
- Packet format: header word (destination address in low ADDR_W bits), then a length word L, then L payload words.
- Header and length are consumed and never forwarded; the payload is routed to the channel whose configured address matches.
- Adds backpressure on insufficient FIFO space, a drop path for unroutable packets, and a saturating drop counter.

---
 rtl/yas_router_n.sv | 145 ++++++++++++++
 tb/tb_yas_router_n.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yas_router_n.sv
// yas_router_n: byte-serial packet router, NUM_CH store-and-forward FIFOs.
// Space is reserved at the length word so DATA never overflows.
module yas_router_n #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int DEPTH_LOG2 = 6,
  parameter int CFG_AW     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         data_in_req,
  output logic                         data_in_ack,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            data_out_req,
  input  logic [NUM_CH-1:0]            data_out_ack,
  input  logic [CFG_AW-1:0]            config_addr,
  input  logic [ADDR_W-1:0]            config_data,
  input  logic                         config_en,
  output logic [7:0]                   drop_cnt
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int CHW   = $clog2(NUM_CH);
  localparam int CW    = ((DATA_WIDTH > PW) ? DATA_WIDTH : PW) + 1;

  typedef enum logic [1:0] {IDLE, LEN, DATA, DISC} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     addr_reg [NUM_CH];
  logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0]         rd [NUM_CH];
  logic [PW-1:0]         wc [NUM_CH];
  logic [PW-1:0]         ws [NUM_CH];
  logic [PW-1:0]         free [NUM_CH];
  logic [CHW-1:0]        ch_q;
  logic [CHW-1:0]        ch_sel;
  logic                  hit_q;
  logic                  hit;
  logic [DATA_WIDTH-1:0] cnt;
  logic [7:0]            drop_q;
  logic [CW-1:0]         len_w;
  logic [CW-1:0]         free_w;
  logic                  stall;
  logic                  xfer;
  logic                  drop_ev;
  logic                  len_bad;

  // Reverse scan so the lowest matching index is the one left standing.
  always_comb begin
    hit    = 1'b0;
    ch_sel = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (data_in[ADDR_W-1:0] == addr_reg[i]) begin
        hit    = 1'b1;
        ch_sel = CHW'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign data_out[g*DATA_WIDTH +: DATA_WIDTH] =
      mem[g][rd[g][DEPTH_LOG2-1:0]];
    assign data_out_req[g] = (rd[g] != wc[g]);
    assign free[g] = PW'(DEPTH) - (ws[g] - rd[g]);
  end

  assign len_w   = CW'(data_in);
  assign free_w  = CW'(free[ch_q]);
  assign len_bad = (len_w > CW'(DEPTH));
  assign stall   = (state == LEN) && hit_q && (len_w != '0) &&
                   !len_bad && (free_w < len_w);
  assign data_in_ack = !rst && !stall;
  assign xfer        = data_in_req && data_in_ack;
  assign drop_ev     = xfer && (state == LEN) &&
                       ((len_w == '0) || !hit_q || len_bad);
  assign drop_cnt    = drop_q;

  always_ff @(posedge clk) begin
    if (xfer && state == DATA)
      mem[ch_q][ws[ch_q][DEPTH_LOG2-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hit_q  <= 1'b0;
      ch_q   <= '0;
      cnt    <= '0;
      drop_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rd[i]       <= '0;
        wc[i]       <= '0;
        ws[i]       <= '0;
        addr_reg[i] <= ADDR_W'(i);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (config_en && config_addr == CFG_AW'(i))
          addr_reg[i] <= config_data;
        if (data_out_req[i] && data_out_ack[i])
          rd[i] <= rd[i] + 1'b1;
      end
      if (drop_ev && drop_q != 8'hff)
        drop_q <= drop_q + 8'd1;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            hit_q <= hit;
            ch_q  <= ch_sel;
            state <= LEN;
          end
          LEN: begin
            cnt <= data_in;
            if (len_w == '0)
              state <= IDLE;
            else if (!hit_q || len_bad)
              state <= DISC;
            else
              state <= DATA;
          end
          DATA: begin
            ws[ch_q] <= ws[ch_q] + 1'b1;
            if (cnt == DATA_WIDTH'(1)) begin
              wc[ch_q] <= ws[ch_q] + 1'b1;
              state    <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DISC: begin
            if (cnt == DATA_WIDTH'(1))
              state <= IDLE;
            else
              cnt <= cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yas_router_n.sv
// tb_yas_router_n: scenario tasks against a queue-based packet model.
// Model tracks committed words per channel, channel addresses and drops.
module tb_yas_router_n;

  localparam int DW    = 8;
  localparam int N     = 3;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_in_req;
  logic          data_in_ack;
  logic [N*DW-1:0] data_out;
  logic [N-1:0]  data_out_req;
  logic [N-1:0]  data_out_ack;
  logic [1:0]    config_addr;
  logic [1:0]    config_data;
  logic          config_en;
  logic [7:0]    drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] q [N][$];
  int maddr [N];
  int mdrop;

  yas_router_n dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_req(data_in_req), .data_in_ack(data_in_ack),
    .data_out(data_out), .data_out_req(data_out_req),
    .data_out_ack(data_out_ack),
    .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      maddr[i] = i;
    end
    mdrop = 0;
  endtask

  task automatic send_word(input logic [7:0] w);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    data_in = w;
    data_in_req = 1'b1;
    while (!done && n < 300) begin
      @(negedge clk);
      done = data_in_ack;
      @(posedge clk);
      #1;
      n++;
    end
    data_in_req = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout word=%h ack never seen", w);
    end
  endtask

  task automatic cfg(input int ch, input int val);
    config_addr = ch[1:0];
    config_data = val[1:0];
    config_en = 1'b1;
    tick();
    config_en = 1'b0;
    if (ch < N) maddr[ch] = val;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len,
                          input int cfg_ch, input int cfg_val);
    int dst;
    logic [7:0] pl [$];
    dst = -1;
    for (int i = N-1; i >= 0; i--)
      if (int'(hdr[1:0]) == maddr[i]) dst = i;
    send_word(hdr);
    send_word(len[7:0]);
    if (cfg_ch >= 0) cfg(cfg_ch, cfg_val);
    for (int k = 0; k < len; k++) begin
      pl.push_back(8'($urandom));
      send_word(pl[k]);
    end
    if (len == 0 || dst < 0 || len > DEPTH)
      mdrop = (mdrop < 255) ? mdrop + 1 : 255;
    else
      foreach (pl[k]) q[dst].push_back(pl[k]);
  endtask

  task automatic drain(input int ch);
    logic [7:0] exp;
    data_out_ack[ch] = 1'b1;
    while (q[ch].size() > 0) begin
      exp = q[ch].pop_front();
      @(negedge clk);
      checks++;
      if (data_out_req[ch] !== 1'b1 || data_out[ch*DW +: DW] !== exp) begin
        errors++;
        $display("FAIL drain ch%0d got req=%b data=%h want req=1 data=%h",
                 ch, data_out_req[ch], data_out[ch*DW +: DW], exp);
      end
      @(posedge clk);
      #1;
    end
    data_out_ack[ch] = 1'b0;
    @(negedge clk);
    checks++;
    if (data_out_req[ch] !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty ch%0d got req=%b want 0", ch, data_out_req[ch]);
    end
    tick();
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    checks++;
    if (data_out_req !== 3'b000 || drop_cnt !== 8'(mdrop)) begin
      errors++;
      $display("FAIL %s got req=%b drop=%0d want req=000 drop=%0d",
               name, data_out_req, drop_cnt, mdrop);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = '0;
    data_in_req = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (data_in_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got %b want 0", data_in_ack);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_req = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (data_out_req !== 3'b000 || drop_cnt !== 8'd0 || data_in_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got req=%b drop=%0d ack=%b want 000 0 1",
               data_out_req, drop_cnt, data_in_ack);
    end
    tick();
  endtask

  task automatic test_commit();
    logic [7:0] pl [3];
    pl[0] = 8'hA1;
    pl[1] = 8'hA2;
    pl[2] = 8'hA3;
    send_word(8'h01);
    send_word(8'd3);
    send_word(pl[0]);
    send_word(pl[1]);
    data_in = pl[2];
    data_in_req = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out_req !== 3'b000 || data_in_ack !== 1'b1) begin
      errors++;
      $display("FAIL commit_early got req=%b ack=%b want 000 1",
               data_out_req, data_in_ack);
    end
    @(posedge clk);
    #1;
    data_in_req = 1'b0;
    checks++;
    if (data_out_req !== 3'b010) begin
      errors++;
      $display("FAIL commit_visible got req=%b want 010", data_out_req);
    end
    foreach (pl[k]) q[1].push_back(pl[k]);
    drain(1);
  endtask

  task automatic test_priority();
    cfg(2, 0);
    send_pkt(8'h00, 2, 0, 3);
    @(negedge clk);
    checks++;
    if (data_out_req !== 3'b001) begin
      errors++;
      $display("FAIL priority_req got %b want 001", data_out_req);
    end
    tick();
    drain(0);
    check_idle_outputs("priority_after");
    cfg(0, 0);
    cfg(2, 2);
  endtask

  task automatic test_backpressure();
    send_pkt(8'h00, 62, -1, 0);
    send_word(8'h00);
    data_in = 8'd4;
    data_in_req = 1'b1;
    @(negedge clk);
    checks++;
    if (data_in_ack !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got ack=%b want 0", data_in_ack);
    end
    data_out_ack[0] = 1'b1;
    @(posedge clk);
    #1;
    void'(q[0].pop_front());
    @(negedge clk);
    checks++;
    if (data_in_ack !== 1'b0) begin
      errors++;
      $display("FAIL bp_one_pop got ack=%b want 0", data_in_ack);
    end
    @(posedge clk);
    #1;
    void'(q[0].pop_front());
    data_out_ack[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (data_in_ack !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ack=%b want 1", data_in_ack);
    end
    @(posedge clk);
    #1;
    data_in_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q[0].push_back(8'($urandom));
      send_word(q[0][q[0].size()-1]);
    end
    drain(0);
  endtask

  task automatic test_drop();
    for (int i = 0; i < N; i++) cfg(i, 3);
    send_pkt(8'h00, 5, -1, 0);
    check_idle_outputs("drop_nomatch");
    send_pkt(8'h00, 0, -1, 0);
    check_idle_outputs("drop_zero");
    for (int i = 0; i < N; i++) cfg(i, i);
    send_pkt(8'h00, 65, -1, 0);
    check_idle_outputs("drop_long");
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 256; k++) begin
      send_pkt(8'($urandom), 0, -1, 0);
      if (k == 199) check_idle_outputs("sat_mid");
    end
    check_idle_outputs("sat_end");
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_value got %0d want 255", drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    send_pkt(8'h02, 3, -1, 0);
    cfg(0, 1);
    send_word(8'h01);
    send_word(8'd5);
    send_word(8'h11);
    send_word(8'h22);
    rst = 1'b1;
    data_in_req = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (data_in_ack !== 1'b0 || data_out_req !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid got ack=%b req=%b want 0 000",
               data_in_ack, data_out_req);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_req = 1'b0;
    model_reset();
    check_idle_outputs("rst_after");
    send_pkt(8'h01, 4, -1, 0);
    drain(1);
    check_idle_outputs("rst_no_stale");
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0)
        cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      len = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 10));
      send_pkt(8'($urandom), len, -1, 0);
      if (k % 4 == 3) begin
        for (int c = 0; c < N; c++) drain(c);
        check_idle_outputs("rand_round");
      end
    end
  endtask

  initial begin
    data_in = '0;
    data_in_req = 1'b0;
    data_out_ack = '0;
    config_addr = '0;
    config_data = '0;
    config_en = 1'b0;
    rst = 1'b1;
    model_reset();
    test_reset();
    test_commit();
    test_priority();
    test_backpressure();
    test_drop();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
